// File: rtl/i2s_tx.sv
// i2s_tx: serial audio output stage.
// Latches a left/right sample pair once per frame and shifts it out as
// standard I2S (MSB first, one BCLK after the LRCLK edge, left slot while
// LRCLK is low). BCLK and LRCLK are derived from sys_clk by an integer divider.
//
// Ports:
//   sys_clk    - system clock, all logic on its rising edge
//   reset      - synchronous active-high reset (priority over enable)
//   enable     - run when high, idle state when low
//   left_in    - left sample, passed through unchanged
//   right_in   - right sample, passed through unchanged
//   sample_req - one-cycle pulse in the cycle the pair is latched
//   bclk       - bit clock (registered)
//   lrclk      - word select (registered), 0 = left, 1 = right
//   sdata      - serial data (registered), changes only on BCLK falls
module i2s_tx #(
  parameter int CLK_DIV   = 8,
  parameter int SLOT_BITS = 32,
  parameter int SAMPLE_W  = 24
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  output logic                sample_req,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                req_q, req_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [SAMPLE_W-1:0] right_q, right_d;

  logic [BIT_W-1:0]    bit_nxt_s;
  logic                right_slot_s;
  logic [BIT_W-1:0]    slot_s;
  logic [SAMPLE_W-1:0] word_s;
  logic                ser_bit_s;

  // Bit position that the next fall event moves to, and its slot offset.
  assign bit_nxt_s    = (bit_cnt_q == BIT_LAST) ? BIT_W'(0) : bit_cnt_q + BIT_W'(1);
  assign right_slot_s = (bit_nxt_s >= SLOT_N);
  assign slot_s       = right_slot_s ? (bit_nxt_s - SLOT_N) : bit_nxt_s;
  // At b==0 the left hold register is stale, but s==0 is padding anyway.
  assign word_s       = right_slot_s ? right_q : left_q;

  // Serial bit for slot offset s: sample bit [SAMPLE_W-s] for 1..SAMPLE_W, else pad 0.
  always_comb begin
    ser_bit_s = 1'b0;
    for (int i = 1; i <= SAMPLE_W; i++) begin
      if (slot_s == BIT_W'(i)) begin
        ser_bit_s = word_s[SAMPLE_W - i];
      end else begin
        ser_bit_s = ser_bit_s;
      end
    end
  end

  // Next-state: divider, bit counter, framing and sample latch.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    req_d     = 1'b0;
    left_d    = left_q;
    right_d   = right_q;

    if (reset || !enable) begin
      div_cnt_d = DIV_W'(0);
      bit_cnt_d = BIT_LAST;
      bclk_d    = 1'b0;
      lrclk_d   = 1'b0;
      sdata_d   = 1'b0;
      left_d    = SAMPLE_W'(0);
      right_d   = SAMPLE_W'(0);
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = DIV_W'(0);
      bclk_d    = ~bclk_q;
      if (bclk_q) begin
        // Fall event: advance one bit and drive the next data bit.
        bit_cnt_d = bit_nxt_s;
        lrclk_d   = right_slot_s;
        sdata_d   = ser_bit_s;
        if (bit_nxt_s == BIT_W'(0)) begin
          left_d  = left_in;
          right_d = right_in;
          req_d   = 1'b1;
        end else begin
          req_d   = 1'b0;
        end
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      div_cnt_q <= DIV_W'(0);
      bit_cnt_q <= BIT_LAST;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      req_q     <= 1'b0;
      left_q    <= SAMPLE_W'(0);
      right_q   <= SAMPLE_W'(0);
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      req_q     <= req_d;
      left_q    <= left_d;
      right_q   <= right_d;
    end
  end

  assign sample_req = req_q;
  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [23:0] left_in;
  logic [23:0] right_in;
  logic        sample_req;
  logic        bclk;
  logic        lrclk;
  logic        sdata;

  int total = 0;
  int bad   = 0;

  i2s_tx #(.CLK_DIV(2), .SLOT_BITS(32), .SAMPLE_W(24)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .enable     (enable),
    .left_in    (left_in),
    .right_in   (right_in),
    .sample_req (sample_req),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Advance until sample_req is seen (bounded).
  task automatic wait_req(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_req && n < 600);
    total++;
    if (sample_req !== 1'b1) begin
      bad++;
      $display("FAIL %s: sample_req timeout got=%b want=1", name, sample_req);
    end
  endtask

  // Starting in a sample_req cycle, sample sdata on the 64 following BCLK rises.
  // Rise j carries bit b=j; slot words are returned MSB (s=0) at bit 31.
  task automatic capture_frame(input string name, input int chg_at, input logic [23:0] chg_val,
                               output logic [31:0] ls, output logic [31:0] rs);
    int   rises, n, last_rise, per_err, lr_err;
    logic prev_b;
    rises = 0; n = 0; last_rise = -1; per_err = 0; lr_err = 0;
    prev_b = bclk;
    ls = 32'h0; rs = 32'h0;
    while (rises < 64 && n < 400) begin
      tick();
      n++;
      if (!prev_b && bclk) begin
        if (last_rise >= 0 && (n - last_rise) != 4) per_err++;
        last_rise = n;
        if (rises < 32) begin
          ls[31 - rises] = sdata;
          if (lrclk !== 1'b0) lr_err++;
        end else begin
          rs[63 - rises] = sdata;
          if (lrclk !== 1'b1) lr_err++;
        end
        if (rises == chg_at) left_in = chg_val;
        rises++;
      end
      prev_b = bclk;
    end
    total++;
    if (rises !== 64) begin
      bad++;
      $display("FAIL %s_rises: got=%0d want=64", name, rises);
    end
    total++;
    if (per_err !== 0) begin
      bad++;
      $display("FAIL %s_bclk_period: bad intervals got=%0d want=0", name, per_err);
    end
    total++;
    if (lr_err !== 0) begin
      bad++;
      $display("FAIL %s_lrclk_slot: bad samples got=%0d want=0", name, lr_err);
    end
  endtask

  task automatic check_idle(input string name);
    total++;
    if ({bclk, lrclk, sdata, sample_req} !== 4'b0000) begin
      bad++;
      $display("FAIL %s: bclk/lrclk/sdata/req got=%b%b%b%b want=0000", name, bclk, lrclk, sdata, sample_req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    left_in = 24'hA55AF0; right_in = 24'h0F0F0F;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset_hold");
    end
    reset = 1'b0;
    tick();
    check_idle("reset_after");
    tick();
    total++;
    if ({bclk, sample_req} !== 2'b10) begin
      bad++;
      $display("FAIL first_rise: bclk/req got=%b%b want=10", bclk, sample_req);
    end
    tick();
    total++;
    if (sample_req !== 1'b0) begin
      bad++;
      $display("FAIL early_req: got=%b want=0", sample_req);
    end
    tick();
    total++;
    if ({bclk, lrclk, sample_req} !== 3'b001) begin
      bad++;
      $display("FAIL first_req: bclk/lrclk/req got=%b%b%b want=001", bclk, lrclk, sample_req);
    end
  endtask

  task automatic test_serial();
    logic [31:0] ls, rs;
    capture_frame("serial", -1, 24'h0, ls, rs);
    total++;
    if (ls !== {1'b0, 24'hA55AF0, 7'b0}) begin
      bad++;
      $display("FAIL serial_left: got=%h want=%h", ls, {1'b0, 24'hA55AF0, 7'b0});
    end
    total++;
    if (rs !== {1'b0, 24'h0F0F0F, 7'b0}) begin
      bad++;
      $display("FAIL serial_right: got=%h want=%h", rs, {1'b0, 24'h0F0F0F, 7'b0});
    end
  endtask

  task automatic test_free_run();
    int   last_req, run_len, chg_err, wide_err, nreq;
    logic prev_b, prev_lr, prev_sd, prev_req;
    wait_req("free_run_start");
    last_req = 0; run_len = 1; chg_err = 0; wide_err = 0; nreq = 0;
    prev_b = bclk; prev_lr = lrclk; prev_sd = sdata; prev_req = sample_req;
    for (int i = 1; i <= 1024; i++) begin
      tick();
      if ((lrclk !== prev_lr || sdata !== prev_sd) && !(prev_b && !bclk)) chg_err++;
      if (sample_req && prev_req) wide_err++;
      if (sample_req) begin
        nreq++;
        total++;
        if (i - last_req !== 256) begin
          bad++;
          $display("FAIL req_spacing: got=%0d want=256", i - last_req);
        end
        last_req = i;
      end
      if (lrclk === prev_lr) begin
        run_len++;
      end else begin
        total++;
        if (run_len !== 128) begin
          bad++;
          $display("FAIL lrclk_run: lrclk=%b run got=%0d want=128", prev_lr, run_len);
        end
        run_len = 1;
      end
      prev_b = bclk; prev_lr = lrclk; prev_sd = sdata; prev_req = sample_req;
    end
    total++;
    if (nreq !== 4) begin
      bad++;
      $display("FAIL req_count: got=%0d want=4", nreq);
    end
    total++;
    if (wide_err !== 0) begin
      bad++;
      $display("FAIL req_width: wide pulses got=%0d want=0", wide_err);
    end
    total++;
    if (chg_err !== 0) begin
      bad++;
      $display("FAIL change_on_fall: stray changes got=%0d want=0", chg_err);
    end
  endtask

  task automatic test_input_change();
    logic [31:0] ls, rs;
    wait_req("chg_start");
    capture_frame("chg_cur", 10, 24'h123456, ls, rs);
    total++;
    if (ls !== {1'b0, 24'hA55AF0, 7'b0}) begin
      bad++;
      $display("FAIL chg_current_left: got=%h want=%h", ls, {1'b0, 24'hA55AF0, 7'b0});
    end
    wait_req("chg_next");
    capture_frame("chg_next", -1, 24'h0, ls, rs);
    total++;
    if (ls !== {1'b0, 24'h123456, 7'b0}) begin
      bad++;
      $display("FAIL chg_next_left: got=%h want=%h", ls, {1'b0, 24'h123456, 7'b0});
    end
    total++;
    if (rs !== {1'b0, 24'h0F0F0F, 7'b0}) begin
      bad++;
      $display("FAIL chg_next_right: got=%h want=%h", rs, {1'b0, 24'h0F0F0F, 7'b0});
    end
  endtask

  // Advance from a sample_req cycle to the rise that carries bit b=target.
  task automatic run_to_bit(input int target);
    int   rises, n;
    logic prev_b;
    rises = 0; n = 0; prev_b = bclk;
    while (rises <= target && n < 400) begin
      tick();
      n++;
      if (!prev_b && bclk) rises++;
      prev_b = bclk;
    end
  endtask

  task automatic test_enable_drop();
    int req_seen;
    wait_req("drop_start");
    run_to_bit(40);
    total++;
    if ({bclk, lrclk} !== 2'b11) begin
      bad++;
      $display("FAIL drop_pre: bclk/lrclk got=%b%b want=11", bclk, lrclk);
    end
    enable = 1'b0;
    tick();
    check_idle("drop_idle");
    req_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sample_req || bclk) req_seen++;
    end
    total++;
    if (req_seen !== 0) begin
      bad++;
      $display("FAIL drop_quiet: activity got=%0d want=0", req_seen);
    end
    left_in = 24'hC00001;
    enable = 1'b1;
    tick(); tick();
    total++;
    if ({bclk, sample_req} !== 2'b10) begin
      bad++;
      $display("FAIL reen_rise: bclk/req got=%b%b want=10", bclk, sample_req);
    end
    tick(); tick();
    total++;
    if ({bclk, lrclk, sample_req} !== 3'b001) begin
      bad++;
      $display("FAIL reen_req: bclk/lrclk/req got=%b%b%b want=001", bclk, lrclk, sample_req);
    end
    tick(); tick(); tick(); tick();
    total++;
    if ({bclk, lrclk, sdata} !== 3'b001) begin
      bad++;
      $display("FAIL reen_msb: bclk/lrclk/sdata got=%b%b%b want=001", bclk, lrclk, sdata);
    end
  endtask

  task automatic test_reset_pulse();
    logic [31:0] ls, rs;
    wait_req("rst_start");
    run_to_bit(5);
    reset = 1'b1;
    left_in = 24'h5A5A5A; right_in = 24'hF00001;
    tick();
    check_idle("rst_idle");
    reset = 1'b0;
    tick(); tick(); tick();
    total++;
    if (sample_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_early_req: got=%b want=0", sample_req);
    end
    tick();
    total++;
    if ({bclk, lrclk, sample_req} !== 3'b001) begin
      bad++;
      $display("FAIL rst_req: bclk/lrclk/req got=%b%b%b want=001", bclk, lrclk, sample_req);
    end
    capture_frame("rst_frame", -1, 24'h0, ls, rs);
    total++;
    if (ls !== {1'b0, 24'h5A5A5A, 7'b0}) begin
      bad++;
      $display("FAIL rst_left: got=%h want=%h", ls, {1'b0, 24'h5A5A5A, 7'b0});
    end
    total++;
    if (rs !== {1'b0, 24'hF00001, 7'b0}) begin
      bad++;
      $display("FAIL rst_right: got=%h want=%h", rs, {1'b0, 24'hF00001, 7'b0});
    end
  endtask

  initial begin
    test_reset();
    test_serial();
    test_free_run();
    test_input_change();
    test_enable_drop();
    test_reset_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
